// File: rtl/ws2812_frame_sequencer.sv
// Frame loop controller for a WS2812B chain: pattern generation, serial transmit,
// latch gap, rotation advance, with a per-phase watchdog on the two done handshakes.
module ws2812_frame_sequencer #(
  parameter int NUM_LEDS       = 60,
  parameter int ROT_W          = 8,
  parameter int LATCH_CYCLES   = 30000,
  parameter int ROT_DIV        = 4,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             genDone,
  input  logic             txDone,
  output logic             genStart,
  output logic             txStart,
  output logic [ROT_W-1:0] rotation,
  output logic             frameDone,
  output logic             busy,
  output logic             timeoutErr
);

  localparam int MAX_CNT = (TIMEOUT_CYCLES > LATCH_CYCLES) ? TIMEOUT_CYCLES : LATCH_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int FRM_W   = (ROT_DIV > 1) ? $clog2(ROT_DIV) : 1;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LATCH_LAST   = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [FRM_W-1:0] FRM_LAST     = FRM_W'(ROT_DIV - 1);
  localparam logic [ROT_W-1:0] ROT_LAST     = ROT_W'(NUM_LEDS - 1);
  // A one-cycle latch gap must raise frameDone on the very cycle LATCH is entered.
  localparam logic             FD_ON_ENTRY  = (LATCH_CYCLES == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_SEND,
    S_LATCH,
    S_ADV
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [FRM_W-1:0] r_frame_cnt;
  logic [ROT_W-1:0] r_rotation;
  logic             r_gen_start;
  logic             r_tx_start;
  logic             r_frame_done;
  logic             r_busy;
  logic             r_timeout_err;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // NOTE: every register here is written with <= so all of them update from the
  // same pre-edge values; a blocking = would leak new values into later statements.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_frame_cnt   <= '0;
      r_rotation    <= '0;
      r_gen_start   <= 1'b0;
      r_tx_start    <= 1'b0;
      r_frame_done  <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low each cycle; the branches below raise them
      // for exactly one cycle, so no path leaves a pulse stuck high.
      r_gen_start  <= 1'b0;
      r_tx_start   <= 1'b0;
      r_frame_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state     <= S_GEN;
            r_gen_start <= 1'b1;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
          end
        end

        // The done input is ignored while our own start pulse is still on the wire.
        S_GEN: begin
          if (!r_gen_start && genDone) begin
            r_state    <= S_SEND;
            r_tx_start <= 1'b1;
            r_cnt      <= '0;
          end else if (r_cnt == TIMEOUT_LAST) begin
            r_state       <= S_LATCH;
            r_timeout_err <= 1'b1;
            r_cnt         <= '0;
            r_frame_done  <= FD_ON_ENTRY;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        S_SEND: begin
          if (!r_tx_start && txDone) begin
            r_state      <= S_LATCH;
            r_cnt        <= '0;
            r_frame_done <= FD_ON_ENTRY;
          end else if (r_cnt == TIMEOUT_LAST) begin
            r_state       <= S_LATCH;
            r_timeout_err <= 1'b1;
            r_cnt         <= '0;
            r_frame_done  <= FD_ON_ENTRY;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        S_LATCH: begin
          if (r_cnt == LATCH_LAST) begin
            r_state <= S_ADV;
          end else begin
            r_cnt        <= w_cnt_inc;
            r_frame_done <= (w_cnt_inc == LATCH_LAST);
          end
        end

        S_ADV: begin
          if (r_frame_cnt == FRM_LAST) begin
            r_frame_cnt <= '0;
            r_rotation  <= (r_rotation == ROT_LAST) ? '0 : r_rotation + ROT_W'(1);
          end else begin
            r_frame_cnt <= r_frame_cnt + FRM_W'(1);
          end
          if (enable) begin
            r_state     <= S_GEN;
            r_gen_start <= 1'b1;
            r_cnt       <= '0;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign genStart   = r_gen_start;
  assign txStart    = r_tx_start;
  assign rotation   = r_rotation;
  assign frameDone  = r_frame_done;
  assign busy       = r_busy;
  assign timeoutErr = r_timeout_err;

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Bench for ws2812_frame_sequencer: a frame-level timeline model fills per-cycle
// stimulus and expectation tables that are replayed and compared every cycle.
module tb_ws2812_frame_sequencer;

  localparam int NUM_LEDS = 3;
  localparam int ROT_W    = 8;
  localparam int LATCH    = 4;
  localparam int ROT_DIV  = 2;
  localparam int TMO      = 50;
  localparam int NC       = 1024;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             genDone = 1'b0;
  logic             txDone = 1'b0;
  logic             genStart;
  logic             txStart;
  logic [ROT_W-1:0] rotation;
  logic             frameDone;
  logic             busy;
  logic             timeoutErr;

  ws2812_frame_sequencer #(
    .NUM_LEDS       (NUM_LEDS),
    .ROT_W          (ROT_W),
    .LATCH_CYCLES   (LATCH),
    .ROT_DIV        (ROT_DIV),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .genDone    (genDone),
    .txDone     (txDone),
    .genStart   (genStart),
    .txStart    (txStart),
    .rotation   (rotation),
    .frameDone  (frameDone),
    .busy       (busy),
    .timeoutErr (timeoutErr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Per-cycle stimulus and expectations, indexed by cycle number after reset release.
  bit d_en[NC], d_gd[NC], d_td[NC], rst_at[NC];
  bit e_gs[NC], e_ts[NC], e_fd[NC], e_busy[NC], e_to[NC];
  int e_rot[NC];

  int p;
  int m_rot, m_frames;
  bit m_to;
  int rot_seq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic put(input int c, input bit gs, input bit ts, input bit fd, input bit bz);
    e_gs[c]   = gs;
    e_ts[c]   = ts;
    e_fd[c]   = fd;
    e_busy[c] = bz;
    e_rot[c]  = m_rot;
    e_to[c]   = m_to;
  endtask

  task automatic idle(input int n, input bit en_last);
    for (int i = 0; i < n; i++) begin
      put(p + i, 1'b0, 1'b0, 1'b0, 1'b0);
      d_en[p + i] = (i == n - 1) ? en_last : 1'b0;
    end
    p += n;
  endtask

  // One frame starting at its genStart cycle p. g/x: done latency after the start
  // pulse (negative = withheld, watchdog fires). rst_off >= 0: async reset during
  // that LATCH cycle, after which the model restarts from reset values.
  task automatic frame(input int g, input int x, input bit en_next, input bit noisy,
                       input int rst_off);
    int c, q, glen, slen;
    rot_seq.push_back(m_rot);
    glen = (g < 0) ? TMO : g + 1;
    for (int i = 0; i < glen; i++) begin
      put(p + i, i == 0, 1'b0, 1'b0, 1'b1);
      d_en[p + i] = 1'b1;
    end
    if (g >= 0) d_gd[p + g] = 1'b1;
    if (noisy) begin
      d_gd[p]     = 1'b1;
      d_td[p + 1] = 1'b1;
    end
    c = p + glen;
    if (g >= 0) begin
      q    = c;
      slen = (x < 0) ? TMO : x + 1;
      for (int i = 0; i < slen; i++) begin
        put(q + i, 1'b0, i == 0, 1'b0, 1'b1);
        d_en[q + i] = en_next || (i == 0);
      end
      if (x >= 0) d_td[q + x] = 1'b1;
      if (noisy) begin
        d_td[q]     = 1'b1;
        d_gd[q + 1] = 1'b1;
      end
      c = q + slen;
    end
    if (g < 0 || x < 0) m_to = 1'b1;
    for (int i = 0; i < LATCH; i++) begin
      put(c + i, 1'b0, 1'b0, i == LATCH - 1, 1'b1);
      d_en[c + i] = en_next;
      if (i == rst_off) begin
        d_en[c + i]   = 1'b1;
        rst_at[c + i] = 1'b1;
        m_rot    = 0;
        m_frames = 0;
        m_to     = 1'b0;
        p = c + i + 1;
        return;
      end
    end
    if (noisy) begin
      d_gd[c]     = 1'b1;
      d_td[c + 1] = 1'b1;
    end
    c += LATCH;
    put(c, 1'b0, 1'b0, 1'b0, 1'b1);
    d_en[c] = en_next;
    if (noisy) begin
      d_gd[c] = 1'b1;
      d_td[c] = 1'b1;
    end
    m_frames++;
    if (m_frames % ROT_DIV == 0) m_rot = (m_rot + 1) % NUM_LEDS;
    p = c + 1;
  endtask

  int total;
  int to_p;
  int exp_rot_seq[7];

  initial begin
    p = 0; m_rot = 0; m_frames = 0; m_to = 1'b0;

    d_gd[5] = 1'b1;
    d_td[6] = 1'b1;
    idle(21, 1'b1);
    frame(3, 5, 1'b1, 1'b0, -1);
    frame(1, 2, 1'b1, 1'b1, -1);
    frame(2, 1, 1'b1, 1'b0, -1);
    frame(4, 3, 1'b1, 1'b0, -1);
    frame(1, 1, 1'b1, 1'b0, -1);
    frame(2, 2, 1'b1, 1'b0, -1);
    frame(3, 3, 1'b1, 1'b0, -1);
    frame(TMO - 1, 2, 1'b1, 1'b0, -1);
    to_p = p;
    frame(-1, 0, 1'b1, 1'b0, -1);
    frame(2, -1, 1'b1, 1'b0, -1);
    frame(2, 3, 1'b0, 1'b1, -1);
    idle(5, 1'b1);
    frame(2, 2, 1'b1, 1'b0, -1);
    frame(2, 2, 1'b1, 1'b0, 1);
    frame(3, 5, 1'b1, 1'b0, -1);
    frame(1, 1, 1'b0, 1'b0, -1);
    idle(6, 1'b0);
    total = p;

    // Hand-derived timeline of the first frame (genStart at cycle 21, g=3, x=5).
    check("pin_gs_first", e_gs[21], 1);
    check("pin_ts_first", e_ts[25], 1);
    check("pin_fd_first", e_fd[34], 1);
    check("pin_gs_second", e_gs[36], 1);
    exp_rot_seq = '{0, 0, 1, 1, 2, 2, 0};
    for (int i = 0; i < 7; i++)
      check($sformatf("pin_rot_frame%0d", i + 1), rot_seq[i], exp_rot_seq[i]);
    check("pin_to_before", e_to[to_p + TMO - 1], 0);
    check("pin_to_after", e_to[to_p + TMO], 1);

    repeat (2) @(negedge clk);
    check("rst_genStart", genStart, 0);
    check("rst_txStart", txStart, 0);
    check("rst_rotation", rotation, 0);
    check("rst_frameDone", frameDone, 0);
    check("rst_busy", busy, 0);
    check("rst_timeoutErr", timeoutErr, 0);
    reset = 1'b0;

    for (int c = 0; c < total; c++) begin
      check($sformatf("genStart@%0d", c), genStart, e_gs[c]);
      check($sformatf("txStart@%0d", c), txStart, e_ts[c]);
      check($sformatf("frameDone@%0d", c), frameDone, e_fd[c]);
      check($sformatf("busy@%0d", c), busy, e_busy[c]);
      check($sformatf("rotation@%0d", c), rotation, e_rot[c]);
      check($sformatf("timeoutErr@%0d", c), timeoutErr, e_to[c]);
      enable  = d_en[c];
      genDone = d_gd[c];
      txDone  = d_td[c];
      if (rst_at[c]) begin
        #2 reset = 1'b1;
        #1;
        check("async_genStart", genStart, 0);
        check("async_txStart", txStart, 0);
        check("async_rotation", rotation, 0);
        check("async_frameDone", frameDone, 0);
        check("async_busy", busy, 0);
        check("async_timeoutErr", timeoutErr, 0);
        #1 reset = 1'b0;
      end
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
